// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default framing constants shared by the UART blocks
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
   localparam int DEFAULT_OVERSAMPLE = 16;
   localparam int DEFAULT_DATA_BITS  = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser for asynchronous inputs, with a selectable reset value
module sync_2ff #(
   parameter int WIDTH = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);
   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end
   assign o_sync = r_sync;
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampled 8N1 UART receiver with valid/ack output, framing and overrun flags.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd) and the ParityError pulse.
module uart_rx_oversample
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 Clock,
   input  logic                 nReset,
   input  logic                 OversampleTick,
   input  logic                 RxSerial,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 RxValid,
   input  logic                 RxAck,
   output logic                 FramingError,
   output logic                 Overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 ParityError
`endif
);
   localparam int TCW = $clog2(OVERSAMPLE);
   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam logic [TCW-1:0] TC_MID  = TCW'(OVERSAMPLE / 2 - 1);
   localparam logic [TCW-1:0] TC_END  = TCW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);

   rx_state_t            r_state;
   logic [TCW-1:0]       r_tc;
   logic [BCW-1:0]       r_bc;
   logic [DATA_BITS-1:0] r_shift;
   logic                 w_sync;
   logic                 w_tc_end;
`ifdef UART_RX_PARITY_EN
   logic                 r_par;
`endif

   sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
      .Clock   (Clock),
      .nReset  (nReset),
      .i_async (RxSerial),
      .o_sync  (w_sync)
   );

   assign w_tc_end = (r_tc == TC_END);

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state      <= IDLE;
         r_tc         <= '0;
         r_bc         <= '0;
         r_shift      <= '0;
         RxData       <= '0;
         RxValid      <= 1'b0;
         FramingError <= 1'b0;
         Overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par        <= 1'b0;
         ParityError  <= 1'b0;
`endif
      end else begin
         FramingError <= 1'b0;
`ifdef UART_RX_PARITY_EN
         ParityError  <= 1'b0;
`endif
         if (RxAck && RxValid) begin
            RxValid <= 1'b0;
            Overrun <= 1'b0;
         end
         if (OversampleTick) begin
            case (r_state)
               IDLE: if (!w_sync) begin
                  r_tc    <= '0;
                  r_state <= START;
               end
               START: if (r_tc == TC_MID) begin
                  r_tc    <= '0;
                  r_bc    <= '0;
                  r_state <= w_sync ? IDLE : DATA;
               end else r_tc <= r_tc + 1'b1;
               DATA: if (w_tc_end) begin
                  r_shift <= {w_sync, r_shift[DATA_BITS-1:1]};
                  r_tc    <= '0;
                  r_bc    <= r_bc + 1'b1;
`ifdef UART_RX_PARITY_EN
                  if (r_bc == BC_LAST) r_state <= PARITY;
`else
                  if (r_bc == BC_LAST) r_state <= STOP;
`endif
               end else r_tc <= r_tc + 1'b1;
`ifdef UART_RX_PARITY_EN
               PARITY: if (w_tc_end) begin
                  r_par   <= w_sync;
                  r_tc    <= '0;
                  r_state <= STOP;
               end else r_tc <= r_tc + 1'b1;
`endif
               STOP: if (w_tc_end) begin
                  r_tc    <= '0;
                  r_state <= IDLE;
                  // A good stop bit overwrites any unconsumed byte; an ack on this edge absorbs it
                  if (w_sync) begin
                     RxData  <= r_shift;
                     RxValid <= 1'b1;
                     if (RxValid && !RxAck) Overrun <= 1'b1;
                  end else FramingError <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  ParityError <= ((^r_shift) ^ r_par) != PARITY_ODD;
`endif
               end else r_tc <= r_tc + 1'b1;
               default: r_state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: scoreboard bench driving serial frames at 64 Clocks per bit.
// Define UART_RX_PARITY_EN to add the parity-error scenario.
module tb_uart_rx_oversample;
   localparam int DB     = 8;
   localparam int OS     = 16;
   localparam int TPC    = 4;
   localparam int BITCLK = OS * TPC;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int LAT = (2 * (DB + PB) + 3) * BITCLK / 2;

   logic          Clock = 1'b0;
   logic          nReset = 1'b0;
   logic          OversampleTick = 1'b0;
   logic          RxSerial = 1'b1;
   logic          RxAck = 1'b0;
   logic [DB-1:0] RxData;
   logic          RxValid;
   logic          FramingError;
   logic          Overrun;
`ifdef UART_RX_PARITY_EN
   logic          ParityError;
`endif

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DB-1:0] q[$];
   logic [DB-1:0] last_byte = '0;

   uart_rx_oversample #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
      .Clock          (Clock),
      .nReset         (nReset),
      .OversampleTick (OversampleTick),
      .RxSerial       (RxSerial),
      .RxData         (RxData),
      .RxValid        (RxValid),
      .RxAck          (RxAck),
      .FramingError   (FramingError),
      .Overrun        (Overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .ParityError    (ParityError)
`endif
   );

   initial forever #5 Clock = ~Clock;

   initial begin
      int k;
      k = 0;
      forever begin
         @(negedge Clock);
         OversampleTick = (k % TPC == TPC - 1);
         k++;
      end
   end

   task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic bad_par);
      RxSerial = 1'b0;
      repeat (BITCLK) @(negedge Clock);
      for (int i = 0; i < DB; i++) begin
         RxSerial = d[i];
         repeat (BITCLK) @(negedge Clock);
      end
      if (PB != 0) begin
         RxSerial = (^d) ^ bad_par;
         repeat (BITCLK) @(negedge Clock);
      end
      RxSerial = stop;
      repeat (40) @(negedge Clock);
      RxSerial = 1'b1;
      repeat (BITCLK - 40) @(negedge Clock);
   endtask

   task automatic wait_out(input int max, output int cyc, output bit v, output bit fe);
      cyc = -1;
      v = 1'b0;
      fe = 1'b0;
      for (int i = 1; i <= max; i++) begin
         @(negedge Clock);
         if (RxValid || FramingError) begin
            cyc = i;
            v = RxValid;
            fe = FramingError;
            break;
         end
      end
   endtask

   task automatic pulse_ack();
      RxAck = 1'b1;
      @(negedge Clock);
      RxAck = 1'b0;
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      RxSerial = 1'b0;
      repeat (5) @(negedge Clock);
      n_cmp += 4;
      if (RxData !== '0) begin n_err++; $display("FAIL reset_data: got %h want 00", RxData); end
      if (RxValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", RxValid); end
      if (FramingError !== 1'b0) begin n_err++; $display("FAIL reset_fe: got %b want 0", FramingError); end
      if (Overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", Overrun); end
      RxSerial = 1'b1;
      repeat (3) @(negedge Clock);
      nReset = 1'b1;
      repeat (20) @(negedge Clock);
   endtask

   task automatic test_frame();
      int cyc;
      bit v, fe;
      q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         wait_out(LAT + 100, cyc, v, fe);
      join
      n_cmp += 5;
      if (v !== 1'b1) begin n_err++; $display("FAIL frame_valid: got %b want 1", v); end
      if (RxData !== q[0]) begin n_err++; $display("FAIL frame_data: got %h want %h", RxData, q[0]); end
      last_byte = q.pop_front();
      if (fe !== 1'b0) begin n_err++; $display("FAIL frame_fe: got %b want 0", fe); end
      if (cyc < LAT || cyc > LAT + 12) begin n_err++; $display("FAIL frame_latency: got %0d want %0d..%0d", cyc, LAT, LAT + 12); end
      pulse_ack();
      if (RxValid !== 1'b0) begin n_err++; $display("FAIL frame_ack: got %b want 0", RxValid); end
   endtask

   task automatic test_glitch();
      int cyc;
      bit v, fe;
      RxSerial = 1'b0;
      repeat (3 * TPC) @(negedge Clock);
      RxSerial = 1'b1;
      wait_out(300, cyc, v, fe);
      n_cmp += 2;
      if (v !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", v); end
      if (fe !== 1'b0) begin n_err++; $display("FAIL glitch_fe: got %b want 0", fe); end
   endtask

   task automatic test_framing();
      int cyc;
      bit v, fe, fe2;
      fork
         send_frame(8'h3C, 1'b0, 1'b0);
         begin
            wait_out(LAT + 100, cyc, v, fe);
            @(negedge Clock);
            fe2 = FramingError;
         end
      join
      repeat (200) @(negedge Clock);
      n_cmp += 5;
      if (fe !== 1'b1) begin n_err++; $display("FAIL framing_pulse: got %b want 1", fe); end
      if (fe2 !== 1'b0) begin n_err++; $display("FAIL framing_width: got %b want 0", fe2); end
      if (v !== 1'b0) begin n_err++; $display("FAIL framing_valid: got %b want 0", v); end
      if (RxValid !== 1'b0) begin n_err++; $display("FAIL framing_valid_after: got %b want 0", RxValid); end
      if (RxData !== last_byte) begin n_err++; $display("FAIL framing_data: got %h want %h", RxData, last_byte); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit v, fe;
      q.push_back(8'h11);
      q.push_back(8'h22);
      fork
         send_frame(8'h11, 1'b1, 1'b0);
         wait_out(LAT + 100, cyc, v, fe);
      join
      n_cmp += 1;
      if (RxData !== q[0] || v !== 1'b1) begin n_err++; $display("FAIL b2b_first: got %h/%b want %h/1", RxData, v, q[0]); end
      void'(q.pop_front());
      send_frame(8'h22, 1'b1, 1'b0);
      n_cmp += 5;
      if (RxData !== q[0]) begin n_err++; $display("FAIL b2b_second: got %h want %h", RxData, q[0]); end
      last_byte = q.pop_front();
      if (RxValid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", RxValid); end
      if (Overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun: got %b want 1", Overrun); end
      pulse_ack();
      if (Overrun !== 1'b0) begin n_err++; $display("FAIL b2b_ovr_clear: got %b want 0", Overrun); end
      if (RxValid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_clear: got %b want 0", RxValid); end
   endtask

   task automatic test_reset_midframe();
      int cyc;
      bit v, fe;
      fork
         send_frame(8'hFF, 1'b1, 1'b0);
         begin
            repeat (5 * BITCLK + BITCLK / 2) @(negedge Clock);
            nReset = 1'b0;
            repeat (3) @(negedge Clock);
            n_cmp += 4;
            if (RxData !== '0) begin n_err++; $display("FAIL midrst_data: got %h want 00", RxData); end
            if (RxValid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", RxValid); end
            if (FramingError !== 1'b0) begin n_err++; $display("FAIL midrst_fe: got %b want 0", FramingError); end
            if (Overrun !== 1'b0) begin n_err++; $display("FAIL midrst_ovr: got %b want 0", Overrun); end
            nReset = 1'b1;
         end
      join
      n_cmp += 1;
      if (RxValid !== 1'b0) begin n_err++; $display("FAIL midrst_lost: got %b want 0", RxValid); end
      q.push_back(8'h5A);
      fork
         send_frame(8'h5A, 1'b1, 1'b0);
         wait_out(LAT + 100, cyc, v, fe);
      join
      n_cmp += 2;
      if (v !== 1'b1 || fe !== 1'b0) begin n_err++; $display("FAIL midrst_next_valid: got v=%b fe=%b want v=1 fe=0", v, fe); end
      if (RxData !== q[0]) begin n_err++; $display("FAIL midrst_next_data: got %h want %h", RxData, q[0]); end
      last_byte = q.pop_front();
      pulse_ack();
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int cyc;
      bit v, fe, pe;
      q.push_back(8'h07);
      fork
         send_frame(8'h07, 1'b1, 1'b1);
         begin
            wait_out(LAT + 100, cyc, v, fe);
            pe = ParityError;
         end
      join
      n_cmp += 3;
      if (pe !== 1'b1) begin n_err++; $display("FAIL parity_err: got %b want 1", pe); end
      if (v !== 1'b1) begin n_err++; $display("FAIL parity_valid: got %b want 1", v); end
      if (RxData !== q[0]) begin n_err++; $display("FAIL parity_data: got %h want %h", RxData, q[0]); end
      last_byte = q.pop_front();
      pulse_ack();
   endtask
`endif

   initial begin
      test_reset();
      test_frame();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_reset_midframe();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      n_cmp++;
      if (q.size() != 0) begin n_err++; $display("FAIL scoreboard_left: got %0d want 0", q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end
endmodule
